// File: rtl/pram_sync_bw.sv
// Single-port synchronous RAM with byte enables, selectable read-during-write
// behaviour, optional output register and a clear engine that fills with INIT_VAL.
module pram_sync_bw #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned WR_MODE = 0,
  parameter int unsigned OUT_REG = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     din,
  input  logic                  clr,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_vld,
  output logic                  busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  generate
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
      $error("pram_sync_bw: DATA_W must be a multiple of 8");
    end
    if (WR_MODE > 2) begin : g_bad_wr_mode
      $error("pram_sync_bw: WR_MODE must be 0, 1 or 2");
    end
  endgenerate

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   merged;
  logic [DATA_W-1:0]   s1_data;
  logic                s1_vld;
  logic                acc_wr;

  always_comb begin
    old_word = mem[addr];
    merged   = old_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (be[i]) merged[8*i +: 8] = din[8*i +: 8];
    end
  end

  assign acc_wr = (state == IDLE) && en && we && !clr;

  // Array has no reset; while rst is held the engine keeps rewriting mem[0]
  // with INIT_VAL, which the following clear pass repeats anyway.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[cptr] <= INIT_VAL;
    else if (acc_wr)
      mem[addr] <= merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      cptr    <= '0;
      busy    <= 1'b1;
      s1_data <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= 1'b0;
      case (state)
        CLEAR: begin
          cptr <= cptr + 1'b1;
          if (&cptr) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            busy  <= 1'b1;
            cptr  <= '0;
          end else if (en) begin
            if (!we) begin
              s1_data <= old_word;
              s1_vld  <= 1'b1;
            end else if (WR_MODE == 0) begin
              s1_data <= merged;
              s1_vld  <= 1'b1;
            end else if (WR_MODE == 1) begin
              s1_data <= old_word;
              s1_vld  <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout     <= '0;
          dout_vld <= 1'b0;
        end else begin
          dout     <= s1_data;
          dout_vld <= s1_vld;
        end
      end
    end else begin : g_out_direct
      assign dout     = s1_data;
      assign dout_vld = s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_pram_sync_bw.sv
// Scoreboard bench: four instances (write-first, read-first, no-change,
// registered write-first) share stimulus; expected words are queued per instance.
module tb_pram_sync_bw;

  localparam logic [15:0] INIT = 16'hA5A5;
  localparam int NI = 4;
  localparam int LAT [NI] = '{1, 1, 1, 2};

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, we, clr;
  logic [1:0]  be;
  logic [3:0]  addr;
  logic [15:0] din;
  logic [15:0] dout [NI];
  logic        vld  [NI];
  logic        busy [NI];

  exp_t        sbq [NI][$];
  logic [15:0] model [16];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pram_sync_bw #(.DATA_W(16), .ADDR_W(4), .WR_MODE(0), .OUT_REG(0), .INIT_VAL(INIT)) u_wf (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
    .dout(dout[0]), .dout_vld(vld[0]), .busy(busy[0]));
  pram_sync_bw #(.DATA_W(16), .ADDR_W(4), .WR_MODE(1), .OUT_REG(0), .INIT_VAL(INIT)) u_rf (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
    .dout(dout[1]), .dout_vld(vld[1]), .busy(busy[1]));
  pram_sync_bw #(.DATA_W(16), .ADDR_W(4), .WR_MODE(2), .OUT_REG(0), .INIT_VAL(INIT)) u_nc (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
    .dout(dout[2]), .dout_vld(vld[2]), .busy(busy[2]));
  pram_sync_bw #(.DATA_W(16), .ADDR_W(4), .WR_MODE(0), .OUT_REG(1), .INIT_VAL(INIT)) u_reg (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din), .clr(clr),
    .dout(dout[3]), .dout_vld(vld[3]), .busy(busy[3]));

  // Every dout_vld pulse must match the oldest pending expectation, value and cycle.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (vld[k] === 1'b1) begin
        n_tests++;
        if (sbq[k].size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_vld inst%0d cyc%0d: got dout=%h vld=1, required no output", k, cyc, dout[k]);
        end else begin
          exp_t e;
          e = sbq[k].pop_front();
          if (dout[k] !== e.data || cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL sb_data inst%0d: got %h at cyc %0d, required %h at cyc %0d", k, dout[k], cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int k, logic [15:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + LAT[k];
    sbq[k].push_back(e);
  endtask

  task automatic idle(int n);
    en = 1'b0; we = 1'b0; clr = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(logic [3:0] a);
    en = 1'b1; we = 1'b0; addr = a; be = 2'b00; din = '0; clr = 1'b0;
    for (int k = 0; k < NI; k++) push(k, model[a]);
    step();
  endtask

  task automatic wr(logic [3:0] a, logic [15:0] d, logic [1:0] b);
    logic [15:0] old, nw;
    old = model[a];
    nw  = {b[1] ? d[15:8] : old[15:8], b[0] ? d[7:0] : old[7:0]};
    en = 1'b1; we = 1'b1; addr = a; be = b; din = d; clr = 1'b0;
    push(0, nw);
    push(1, old);
    push(3, nw);
    model[a] = nw;
    step();
  endtask

  // Counts cycles with busy high; called just after the edge that raised busy.
  task automatic count_busy(string name, logic rd_during);
    int n = 0;
    while (busy[0] === 1'b1 && n < 100) begin
      en = rd_during; we = 1'b0; addr = n[3:0]; clr = 1'b0;
      step();
      n++;
    end
    en = 1'b0;
    n_tests++;
    if (n !== 16) begin
      n_fail++;
      $display("FAIL %s busy_len: got %0d cycles, required 16", name, n);
    end
    for (int i = 0; i < 16; i++) model[i] = INIT;
  endtask

  task automatic check_reset_outputs(string name);
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (dout[k] !== 16'h0000 || vld[k] !== 1'b0 || busy[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s inst%0d: got dout=%h vld=%b busy=%b, required dout=0000 vld=0 busy=1",
                 name, k, dout[k], vld[k], busy[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; we = 1'b0; clr = 1'b0; be = '0; addr = '0; din = '0;
    #3;
    check_reset_outputs("reset_state");
    step();
    step();
    rst = 1'b0;
    count_busy("reset_clear", 1'b0);
  endtask

  task automatic test_read_init();
    rd(4'd0);
    rd(4'd15);
    idle(3);
  endtask

  task automatic test_byte_enable();
    wr(4'd3, 16'h1234, 2'b11);
    wr(4'd3, 16'hABCD, 2'b01);
    wr(4'd3, 16'hFFFF, 2'b00);
    rd(4'd3);
    idle(3);
    n_tests++;
    if (model[3] !== 16'h12CD) begin
      n_fail++;
      $display("FAIL be_merge_model: got %h, required 12cd", model[3]);
    end
  endtask

  task automatic test_wr_mode();
    logic [15:0] held;
    wr(4'd7, 16'h0000, 2'b11);
    idle(1);
    held = dout[2];
    wr(4'd7, 16'h5555, 2'b11);
    n_tests++;
    if (vld[2] !== 1'b0 || dout[2] !== held) begin
      n_fail++;
      $display("FAIL no_change_write: got dout=%h vld=%b, required dout=%h vld=0", dout[2], vld[2], held);
    end
    n_tests++;
    if (dout[0] !== 16'h5555 || dout[1] !== 16'h0000) begin
      n_fail++;
      $display("FAIL rdw_modes: got wf=%h rf=%h, required wf=5555 rf=0000", dout[0], dout[1]);
    end
    rd(4'd7);
    idle(3);
  endtask

  task automatic test_back_to_back();
    wr(4'd1, 16'h0011, 2'b11);
    wr(4'd2, 16'h0022, 2'b11);
    wr(4'd3, 16'h0033, 2'b11);
    rd(4'd1);
    rd(4'd2);
    rd(4'd3);
    idle(3);
  endtask

  task automatic test_clr_collision();
    en = 1'b1; we = 1'b1; addr = 4'd5; be = 2'b11; din = 16'hFFFF; clr = 1'b1;
    step();
    clr = 1'b0;
    count_busy("clr_collision", 1'b1);
    rd(4'd5);
    idle(3);
  endtask

  task automatic test_rst_mid_clear();
    wr(4'd8, 16'h1111, 2'b11);
    idle(2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 8; i++) step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_clear");
    step();
    rst = 1'b0;
    count_busy("rst_restart", 1'b0);
    rd(4'd8);
    rd(4'd0);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_read_init();
    test_byte_enable();
    test_wr_mode();
    test_back_to_back();
    test_clr_collision();
    test_rst_mid_clear();
    idle(2);
    for (int k = 0; k < NI; k++) begin
      n_tests++;
      if (sbq[k].size() !== 0) begin
        n_fail++;
        $display("FAIL sb_drain inst%0d: got %0d outputs still pending, required 0", k, sbq[k].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
